ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Built-in self-test initiator for the single/dual-port RAM. It drives one RAM port (addr/din/we in, dout back) with a March C- sequence.
- It compares each read against the expected background and reports pass/fail plus first-failure details.
- Sits between a test/control register block and the RAM port, muxed ahead of functional traffic by the integrator.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin a test run
busy  output  1  high while a test is running
done  output  1  one-cycle pulse at end of run
pass  output  1  result of last run; valid from done, held until next accepted start
fail_addr  output  ADDR_WIDTH  address of first miscompare
fail_exp  output  DATA_WIDTH  expected data at first miscompare
fail_act  output  DATA_WIDTH  actual data at first miscompare
fail_count  output  8  number of miscompares in last run, saturating at 255
ram_addr  output  ADDR_WIDTH  RAM port address
ram_din  output  DATA_WIDTH  RAM port write data
ram_we  output  1  RAM port write enable
ram_dout  input  DATA_WIDTH  RAM port read data; synchronous, valid the cycle after a read address is presented

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_exp=0, fail_act=0, fail_count=0, ram_addr=0, ram_din=0, ram_we=0. State is IDLE, element index 0.
- Backgrounds: "0" = all-zeros word, "1" = all-ones word.
- March C- elements, executed in order:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- Address direction: up = 0..DEPTH-1; down = DEPTH-1..0.
- FSM states: IDLE, WR, RD, CMP, DONE.
- IDLE: start=1 -> WR with elem=0, addr=0. In the same edge, clear pass, fail_* and fail_count.
- WR (E0 only): ram_we=1, ram_din=0, one address per cycle. After DEPTH-1 -> RD, elem=1, addr=0.
- RD: ram_we=0, ram_addr=current address. Always goes to CMP.
- CMP: ram_dout holds the data read in RD; compare it against the element's read background.
  - Elements E1-E4 also write the element's write background at the same address in this cycle (ram_we=1).
  - Next state: advance address in the element's direction -> RD. At the last address of the element: next element (E3 starts at DEPTH-1) -> RD. At the last address of E5 -> DONE.
- Miscompare (default build): on the first one, capture fail_addr/exp/act, set fail_count=1, abort to DONE. The write in that CMP cycle is suppressed.
- DONE: done=1 for exactly one cycle. pass=1 iff fail_count==0. busy=0. Next state is IDLE.
- busy: high in WR, RD and CMP.
- start while busy or in DONE: ignored.
- Cycle count: a clean run is DEPTH + 10*DEPTH cycles in WR/RD/CMP. DEPTH=16 gives 176, with done on cycle 177 after the start edge.
- ram_we is 0 in IDLE, RD and DONE.
- Reset mid-run: returns to IDLE next edge with all reset values. No done pulse; RAM contents are undefined.
- Address counter wraps only by explicit element transition, never by overflow.

Optional Feature:
- Macro: RAM_BIST_NO_ABORT_EN.
- Defined:
  - A miscompare does not abort; the run completes all elements.
  - Only the first miscompare is captured in fail_addr/exp/act.
  - fail_count increments per miscompare, saturating at 255.
  - The CMP write is performed normally.
- Undefined: abort-on-first-fail behaviour as above; fail_count is 0 or 1.

Test Plan:
1. Fault-free 16x8 RAM, pulse start -> busy for 176 cycles; done pulse; pass=1, fail_count=0; final RAM contents all 8'h00.
2. RAM model with bit 3 of addr 4'h5 stuck-at-1 -> first fail in E1 read: fail_addr=4'h5, fail_exp=8'h00, fail_act=8'h08, pass=0. Default build: done well before 176 cycles.
3. Same fault with RAM_BIST_NO_ABORT_EN defined -> full 176-cycle run. fail_addr=4'h5, fail_count=3 (E1, E3, E5 reads of 0 fail), pass=0.
4. Assert rst mid-E3 (cycle 100) -> next cycle busy=0, ram_we=0, pass=0, no done. A subsequent start runs a clean 176-cycle pass.
5. start re-pulsed at cycles 10 and 50 of a run -> ignored. Exactly one done; cycle count unchanged.
6. Protocol check: in every CMP cycle, ram_addr equals the preceding RD address. ram_we is never 1 in RD. E3/E4 addresses are observed descending 4'hF..4'h0.

Source files
------------

// File: rtl/ram_march_bist.sv
// March C- built-in self-test initiator for one synchronous-read RAM port.
// Runs E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1),
// E4 down(r1,w0), E5 up(r0) and reports pass plus first-failure details.
// Optional build macro RAM_BIST_NO_ABORT_EN: keep running after a
// miscompare and count every miscompare (saturating at 255) instead of
// aborting on the first one.
module ram_march_bist #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [7:0]            fail_count,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0] fail_act_q, fail_act_d;
  logic [7:0]            fail_count_q, fail_count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  ram_we_q, ram_we_d;

  logic                  miscmp;
  logic                  abort;
  logic                  down;
  logic                  last_addr;

  // Background read by each element: E2/E4 read ones, the others zeros.
  function automatic logic [DATA_WIDTH-1:0] rd_bg(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? '1 : '0;
  endfunction

  // Background written by each element: E1/E3 write ones, the others zeros.
  function automatic logic [DATA_WIDTH-1:0] wr_bg(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? '1 : '0;
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3 || e == 3'd4);
  endfunction

  function automatic logic has_wr(input logic [2:0] e);
    return (e >= 3'd1 && e <= 3'd4);
  endfunction

  // Read data for the address presented in RD is on ram_dout during CMP.
  assign miscmp    = (state_q == S_CMP) && (ram_dout != rd_bg(elem_q));
  assign down      = is_down(elem_q);
  assign last_addr = down ? (addr_q == '0) : (addr_q == '1);

  // Next-state, address walk and failure capture.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    addr_d       = addr_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_exp_d   = fail_exp_q;
    fail_act_d   = fail_act_q;
    fail_count_d = fail_count_q;
    abort        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_WR;
          elem_d       = 3'd0;
          addr_d       = '0;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_exp_d   = '0;
          fail_act_d   = '0;
          fail_count_d = 8'd0;
        end
      end
      S_WR: begin
        if (addr_q == '1) begin
          state_d = S_RD;
          elem_d  = 3'd1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        if (miscmp) begin
`ifdef RAM_BIST_NO_ABORT_EN
          if (fail_count_q == 8'd0) begin
            fail_addr_d = addr_q;
            fail_exp_d  = rd_bg(elem_q);
            fail_act_d  = ram_dout;
          end
          if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
`else
          fail_addr_d  = addr_q;
          fail_exp_d   = rd_bg(elem_q);
          fail_act_d   = ram_dout;
          fail_count_d = 8'd1;
          abort        = 1'b1;
`endif
        end
        if (abort) begin
          state_d = S_DONE;
        end else if (last_addr) begin
          if (elem_q == 3'd5) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            elem_d  = elem_q + 3'd1;
            addr_d  = is_down(elem_q + 3'd1) ? '1 : '0;
          end
        end else begin
          state_d = S_RD;
          addr_d  = down ? addr_q - 1'b1 : addr_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE) pass_d = (fail_count_d == 8'd0);
    busy_d    = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_CMP);
    done_d    = (state_d == S_DONE);
    ram_we_d  = (state_d == S_WR) || (state_d == S_CMP && has_wr(elem_d));
    ram_din_d = (state_d == S_CMP) ? wr_bg(elem_d) : '0;
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      elem_q       <= 3'd0;
      addr_q       <= '0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_exp_q   <= '0;
      fail_act_q   <= '0;
      fail_count_q <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_exp_q   <= fail_exp_d;
      fail_act_q   <= fail_act_d;
      fail_count_q <= fail_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_exp   = fail_exp_q;
  assign fail_act   = fail_act_q;
  assign fail_count = fail_count_q;
  assign ram_addr   = addr_q;
  assign ram_din    = ram_din_q;

  // The CMP write must be dropped when that same cycle's read miscompares
  // and the run aborts; read data only arrives in CMP, so the gate is late.
`ifdef RAM_BIST_NO_ABORT_EN
  assign ram_we = ram_we_q;
`else
  assign ram_we = ram_we_q & ~miscmp;
`endif

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: behavioural RAM with injectable stuck bits, a
// March C- reference that expands each run into a per-cycle expectation
// queue, and one compare process that checks the DUT every cycle.
module tb_ram_march_bist;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;
`ifdef RAM_BIST_NO_ABORT_EN
  localparam bit ABORT = 1'b0;
`else
  localparam bit ABORT = 1'b1;
`endif

  logic          clk, rst, start;
  logic          busy, done, pass, ram_we;
  logic [AW-1:0] fail_addr, ram_addr;
  logic [DW-1:0] fail_exp, fail_act, ram_din, ram_dout;
  logic [7:0]    fail_count;

  ram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
    .fail_count(fail_count), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous read, stuck-at faults applied on read.
  logic [DW-1:0] ram_mem [D];
  bit            fault_en;
  logic [AW-1:0] fault_addr;
  logic [DW-1:0] stuck1, stuck0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    if (fault_en && ram_addr == fault_addr)
      ram_dout <= (ram_mem[ram_addr] | stuck1) & ~stuck0;
    else
      ram_dout <= ram_mem[ram_addr];
  end

  typedef struct packed {
    logic          busy, done, we, res, pass;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [7:0]    fcnt;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fexp, fact;
  } exp_t;

  exp_t          trace[$];
  exp_t          idle_e;
  exp_t          ce;
  int            trace_len;
  logic [DW-1:0] model_mem [D];
  int            n_cmp = 0, n_fail = 0;
  int            busy_total = 0, done_total = 0;
  logic [AW-1:0] addr_log [256];
  logic          we_log [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, expv);
    end
  endtask

  // Expand one March C- run into the exact cycle sequence the port must show.
  task automatic build_run(input bit fen, input logic [AW-1:0] fa,
                           input logic [DW-1:0] s1, input logic [DW-1:0] s0);
    exp_t          e;
    int            cnt, a;
    bit            stop, mis;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fexp, fact, rv, rb;
    cnt = 0; stop = 0; faddr = '0; fexp = '0; fact = '0;
    trace.delete();
    e = '0;
    e.busy = 1'b1;
    for (int i = 0; i < D; i++) begin
      e.we = 1'b1; e.addr = AW'(i); e.din = '0;
      trace.push_back(e);
      model_mem[i] = '0;
    end
    for (int el = 1; el <= 5 && !stop; el++) begin
      for (int k = 0; k < D && !stop; k++) begin
        a  = (el == 3 || el == 4) ? D - 1 - k : k;
        rb = (el == 2 || el == 4) ? {DW{1'b1}} : {DW{1'b0}};
        e.we = 1'b0; e.addr = AW'(a); e.din = '0; e.fcnt = 8'(cnt);
        trace.push_back(e);
        rv = model_mem[a];
        if (fen && AW'(a) == fa) rv = (rv | s1) & ~s0;
        mis = (rv != rb);
        if (mis && cnt == 0) begin faddr = AW'(a); fexp = rb; fact = rv; end
        e.we  = (el <= 4) && !(ABORT && mis);
        e.din = ~rb;
        trace.push_back(e);
        if (e.we) model_mem[a] = ~rb;
        if (mis) begin
          if (cnt < 255) cnt++;
          if (ABORT) stop = 1;
        end
      end
    end
    e = '0;
    e.done = 1'b1; e.res = 1'b1; e.pass = (cnt == 0); e.fcnt = 8'(cnt);
    e.faddr = faddr; e.fexp = fexp; e.fact = fact;
    trace.push_back(e);
    idle_e = e;
    idle_e.done = 1'b0;
    trace_len = trace.size();
  endtask

  // Single compare process: next expectation, or the idle expectation.
  always @(posedge clk) begin
    int cyc;
    #1;
    cyc = 0;
    if (trace.size() > 0) begin
      ce  = trace.pop_front();
      cyc = trace_len - trace.size();
    end else begin
      ce = idle_e;
    end
    chk("busy", 32'(busy), 32'(ce.busy));
    chk("done", 32'(done), 32'(ce.done));
    chk("ram_we", 32'(ram_we), 32'(ce.we));
    if (ce.busy) chk("ram_addr", 32'(ram_addr), 32'(ce.addr));
    if (ce.we) chk("ram_din", 32'(ram_din), 32'(ce.din));
    chk("pass", 32'(pass), 32'(ce.pass));
    chk("fail_count", 32'(fail_count), 32'(ce.fcnt));
    if (ce.res) begin
      chk("fail_addr", 32'(fail_addr), 32'(ce.faddr));
      chk("fail_exp", 32'(fail_exp), 32'(ce.fexp));
      chk("fail_act", 32'(fail_act), 32'(ce.fact));
    end
    if (busy) busy_total++;
    if (done) done_total++;
    if (cyc > 0 && cyc < 256) begin
      addr_log[cyc] = ram_addr;
      we_log[cyc]   = ram_we;
    end
  end

  int base_busy, base_done;

  // One run: pulse start, optionally re-pulse start mid-run, wait bounded.
  task automatic run(input bit fen, input logic [AW-1:0] fa, input logic [DW-1:0] s1,
                     input logic [DW-1:0] s0, input bit repulse);
    @(negedge clk);
    fault_en = fen; fault_addr = fa; stuck1 = s1; stuck0 = s0;
    build_run(fen, fa, s1, s0);
    base_busy = busy_total;
    base_done = done_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 400 && trace.size() > 0; i++) begin
      start = repulse && (i == 10 || i == 50);
      @(negedge clk);
    end
    start = 1'b0;
    if (trace.size() > 0) begin
      n_cmp++; n_fail++;
      $display("FAIL run_timeout: %0d expected cycles left, want 0", trace.size());
      trace.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fault_en = 0; fault_addr = '0; stuck1 = '0; stuck0 = '0;
    idle_e = '0;
    trace_len = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_ram_addr", 32'(ram_addr), 32'd0);
    chk("reset_ram_din", 32'(ram_din), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run.
    run(0, '0, '0, '0, 0);
    chk("clean_busy_cycles", 32'(busy_total - base_busy), 32'd176);
    chk("clean_done_count", 32'(done_total - base_done), 32'd1);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_fail_count", 32'(fail_count), 32'd0);
    chk("e3_first_addr", 32'(addr_log[81]), 32'hF);
    chk("e3_first_rd_we", 32'(we_log[81]), 32'd0);
    chk("e3_last_addr", 32'(addr_log[112]), 32'h0);
    chk("e3_last_cmp_we", 32'(we_log[112]), 32'd1);
    for (int a = 0; a < D; a++) chk("clean_ram_final", 32'(ram_mem[a]), 32'h00);

    // Bit 3 of address 5 stuck at 1.
    run(1, 4'h5, 8'h08, 8'h00, 0);
    chk("sa1_fail_addr", 32'(fail_addr), 32'h5);
    chk("sa1_fail_exp", 32'(fail_exp), 32'h00);
    chk("sa1_fail_act", 32'(fail_act), 32'h08);
    chk("sa1_pass", 32'(pass), 32'd0);
`ifdef RAM_BIST_NO_ABORT_EN
    chk("sa1_fail_count", 32'(fail_count), 32'd3);
    chk("sa1_busy_cycles", 32'(busy_total - base_busy), 32'd176);
`else
    chk("sa1_fail_count", 32'(fail_count), 32'd1);
    chk("sa1_busy_cycles", 32'(busy_total - base_busy), 32'd28);
`endif
    for (int a = 0; a < D; a++) chk("sa1_ram_final", 32'(ram_mem[a]), 32'(model_mem[a]));

    // Reset in the middle of E3.
    @(negedge clk);
    fault_en = 0;
    build_run(0, '0, '0, '0);
    base_done = done_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    trace.delete();
    idle_e = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(done_total - base_done), 32'd0);
    run(0, '0, '0, '0, 0);
    chk("postrst_busy_cycles", 32'(busy_total - base_busy), 32'd176);
    chk("postrst_pass", 32'(pass), 32'd1);

    // start re-pulsed while busy must be ignored.
    run(0, '0, '0, '0, 1);
    chk("repulse_busy_cycles", 32'(busy_total - base_busy), 32'd176);
    chk("repulse_done_count", 32'(done_total - base_done), 32'd1);

    // Randomised faults and idle gaps.
    for (int r = 0; r < 8; r++) begin
      logic [DW-1:0] m;
      m = DW'(1) << $urandom_range(0, DW - 1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if ($urandom_range(0, 1) == 1)
        run(1, AW'($urandom_range(0, D - 1)), m, '0, $urandom_range(0, 1) == 1);
      else
        run($urandom_range(0, 3) != 0, AW'($urandom_range(0, D - 1)), '0, m, 0);
      for (int a = 0; a < D; a++) chk("rand_ram_final", 32'(ram_mem[a]), 32'(model_mem[a]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
